rtc_set_ctrl: RTL and testbench
===============================

# rtc_set_ctrl

Time-setting controller for the real-time clock's hour/minute counter chain. It sequences a two-button user interface (mode, increment) through hour and minute edit states and holds an editable shadow copy of the time. It freezes the counter chain while editing and issues a single-cycle parallel load to the counters on commit. It sits between the debounced button logic and the RTC counter chain, and also drives the display blink enable.

## Interface

Parameters:
- AUTO_EXIT_S, default 30: seconds without a button press in an edit state before abandoning the edit; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-clk-wide strobe once per second
- mode_btn  in  1  debounced one-clk pulse, advances edit state
- inc_btn  in  1  debounced one-clk pulse, increments the field being edited
- cur_hrm, cur_hrl, cur_minm, cur_minl  in  4 each  live BCD time from the counter chain
- count_en  out  1  enable for the counter chain; 0 freezes time
- load  out  1  one-clk parallel-load strobe to the counter chain (seconds cleared by the chain on load)
- ld_hrm, ld_hrl, ld_minm, ld_minl  out  4 each  BCD load values (shadow registers)
- edit_field  out  2  0 = none, 1 = hours, 2 = minutes
- blink  out  1  display blank phase for the edited field

## Operation

- States: RUN, SET_HR, SET_MIN, COMMIT.
- RUN: mode_btn -> SET_HR; on the same edge, shadow <= cur_* values.
- SET_HR:
  - inc_btn -> hours +1 in BCD, 23 -> 00.
  - mode_btn -> SET_MIN.
- SET_MIN:
  - inc_btn -> minutes +1 in BCD, 59 -> 00.
  - Minute wrap never carries into hours.
  - mode_btn -> COMMIT.
- COMMIT: lasts exactly one clk; load=1; next state RUN unconditionally. Buttons are ignored.
- Timeout:
  - idle counter, width $clog2(AUTO_EXIT_S+1), cleared on entry to SET_HR and on any button press.
  - Increments on tick_1hz in SET_HR/SET_MIN.
  - When it reaches AUTO_EXIT_S, the next state is RUN with no load; the counter chain resumes from the frozen time.
- Simultaneous mode_btn and inc_btn: mode wins; the increment is dropped.
- Simultaneous timeout and button on the same edge: the button wins (idle counter clears).
- blink: toggles on each tick_1hz in SET_HR/SET_MIN; forced 0 in RUN/COMMIT and on entry to SET_HR.
- count_en = 1 only in RUN.
- edit_field: 1 in SET_HR, 2 in SET_MIN, 0 otherwise.
- Shadow hour values 0..23 and minute values 0..59 always; every digit stays legal BCD.

## Timing

- All outputs are registered, Moore-style from state.
- Reset values: state RUN, count_en=1, load=0, ld_* = 0, edit_field=0, blink=0, idle counter=0.
- mode_btn in RUN at edge N -> count_en=0 and edit_field=1 after edge N.
- inc_btn at edge N -> updated ld_* visible after edge N.
- mode_btn in SET_MIN at edge N:
  - load=1 for the cycle following edge N (state COMMIT).
  - count_en returns to 1 one cycle later.
- The counter chain must sample load before it sees count_en=1; ld_* are stable throughout the load cycle.
- rst asserted mid-edit: immediate abort to reset values; no load is issued.
- tick_1hz coincident with entry to SET_HR: not counted toward timeout.

## Structure

- Shared package rtc_pkg:
  - state enum (RUN, SET_HR, SET_MIN, COMMIT)
  - edit_field encodings
  - BCD limit constants (HR_MAX = 23, MIN_MAX = 59)
- One sub-module, bcd2_inc: two-digit BCD +1 with a parameterized wrap value (tens/units max). Instantiated once for hours (wrap 23) and once for minutes (wrap 59).
- FSM, shadow registers, idle counter and blink flop live in rtc_set_ctrl.

## Test plan

- Reset release: count_en=1, load=0, ld_*=0, edit_field=0 -> no load over 1000 clks.
- cur=12:34; sequence mode, inc×3, mode, inc×30, mode:
  - single load pulse with ld = 15:04
  - count_en low from first mode through COMMIT
- Hour wrap: capture 22:00, inc×2 in SET_HR -> 00. Minute wrap: 58, inc×3 -> 01, hours unchanged.
- Same-cycle mode+inc in SET_HR -> state SET_MIN, hours unchanged.
- AUTO_EXIT_S=3: enter SET_HR, no buttons, 3 ticks -> RUN, count_en=1, no load. Repeat with inc on the third tick -> stays in SET_HR.
- rst pulse while in SET_MIN -> all outputs at reset values; no load at any point afterward.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-setting controller.
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_e;

  localparam logic [1:0] EF_NONE    = 2'd0;
  localparam logic [1:0] EF_HOURS   = 2'd1;
  localparam logic [1:0] EF_MINUTES = 2'd2;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;

  function automatic logic is_edit(input state_e s);
    return (s == SET_HR) || (s == SET_MIN);
  endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD increment that wraps to 00 after TENS_MAX:UNITS_MAX.
module bcd2_inc #(
  parameter int unsigned TENS_MAX  = 5,
  parameter int unsigned UNITS_MAX = 9
) (
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  localparam logic [3:0] TMAX = 4'(TENS_MAX);
  localparam logic [3:0] UMAX = 4'(UNITS_MAX);

  logic wrap;

  // Out-of-range inputs also fold to 00 so the result is always legal.
  assign wrap = (tens_i > TMAX) || (units_i > 4'd9) ||
                ((tens_i == TMAX) && (units_i >= UMAX));

  always_comb begin
    tens_o  = tens_i;
    units_o = units_i + 4'd1;
    if (wrap) begin
      tens_o  = '0;
      units_o = '0;
    end else if (units_i == 4'd9) begin
      tens_o  = tens_i + 4'd1;
      units_o = '0;
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Two-button time-setting controller: edits a shadow copy of hh:mm while the
// counter chain is frozen, then issues a single-cycle parallel load.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned AUTO_EXIT_S = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_hrm,
  input  logic [3:0] cur_hrl,
  input  logic [3:0] cur_minm,
  input  logic [3:0] cur_minl,
  output logic       count_en,
  output logic       load,
  output logic [3:0] ld_hrm,
  output logic [3:0] ld_hrl,
  output logic [3:0] ld_minm,
  output logic [3:0] ld_minl,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int unsigned IDLE_W = (AUTO_EXIT_S > 0) ? $clog2(AUTO_EXIT_S + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((AUTO_EXIT_S == 0) ? 0 : AUTO_EXIT_S - 1);

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              blink_q, blink_d;
  logic              count_en_q, load_q;
  logic [1:0]        edit_field_q;
  logic [3:0]        hrm_q, hrl_q, minm_q, minl_q;
  logic [3:0]        hrm_d, hrl_d, minm_d, minl_d;
  logic [3:0]        hr_inc_t, hr_inc_u, min_inc_t, min_inc_u;
  logic              timeout;

  bcd2_inc #(.TENS_MAX(HR_MAX / 10), .UNITS_MAX(HR_MAX % 10)) u_hr_inc (
    .tens_i (hrm_q),
    .units_i(hrl_q),
    .tens_o (hr_inc_t),
    .units_o(hr_inc_u)
  );

  bcd2_inc #(.TENS_MAX(MIN_MAX / 10), .UNITS_MAX(MIN_MAX % 10)) u_min_inc (
    .tens_i (minm_q),
    .units_i(minl_q),
    .tens_o (min_inc_t),
    .units_o(min_inc_u)
  );

  // Expires on the tick that would bring the idle count to AUTO_EXIT_S;
  // any button on that edge takes priority.
  assign timeout = (AUTO_EXIT_S != 0) && tick_1hz && (idle_q == IDLE_LAST) &&
                   !mode_btn && !inc_btn;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mode_btn) state_d = SET_HR;
      SET_HR:  if (mode_btn) state_d = SET_MIN; else if (timeout) state_d = RUN;
      SET_MIN: if (mode_btn) state_d = COMMIT;  else if (timeout) state_d = RUN;
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hrm_d  = hrm_q;
    hrl_d  = hrl_q;
    minm_d = minm_q;
    minl_d = minl_q;
    if (state_q == RUN && mode_btn) begin
      hrm_d  = cur_hrm;
      hrl_d  = cur_hrl;
      minm_d = cur_minm;
      minl_d = cur_minl;
    end else if (state_q == SET_HR && inc_btn && !mode_btn) begin
      hrm_d = hr_inc_t;
      hrl_d = hr_inc_u;
    end else if (state_q == SET_MIN && inc_btn && !mode_btn) begin
      minm_d = min_inc_t;
      minl_d = min_inc_u;
    end
  end

  always_comb begin
    idle_d  = idle_q;
    blink_d = blink_q;
    if (!is_edit(state_d) || state_q == RUN || mode_btn || inc_btn) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (!is_edit(state_d) || state_q == RUN) begin
      blink_d = 1'b0;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      idle_q       <= '0;
      blink_q      <= 1'b0;
      count_en_q   <= 1'b1;
      load_q       <= 1'b0;
      edit_field_q <= EF_NONE;
      hrm_q        <= '0;
      hrl_q        <= '0;
      minm_q       <= '0;
      minl_q       <= '0;
    end else begin
      state_q      <= state_d;
      idle_q       <= idle_d;
      blink_q      <= blink_d;
      count_en_q   <= (state_d == RUN);
      load_q       <= (state_d == COMMIT);
      edit_field_q <= (state_d == SET_HR)  ? EF_HOURS :
                      (state_d == SET_MIN) ? EF_MINUTES : EF_NONE;
      hrm_q        <= hrm_d;
      hrl_q        <= hrl_d;
      minm_q       <= minm_d;
      minl_q       <= minl_d;
    end
  end

  assign count_en   = count_en_q;
  assign load       = load_q;
  assign edit_field = edit_field_q;
  assign blink      = blink_q;
  assign ld_hrm     = hrm_q;
  assign ld_hrl     = hrl_q;
  assign ld_minm    = minm_q;
  assign ld_minl    = minl_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Randomized and directed bench for rtc_set_ctrl against an integer-time model,
// exercising a default-timeout instance and a 3-second-timeout instance.
module tb_rtc_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, mode_btn, inc_btn;
  logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl;
  logic       ce0, ld0, bl0, ce1, ld1, bl1;
  logic [1:0] ef0, ef1;
  logic [3:0] hm0, hl0, mm0, ml0, hm1, hl1, mm1, ml1;

  int unsigned n_chk = 0, n_pass = 0;
  int          m[2], h[2], mi[2], idle[2], lim[2];
  bit          bl[2];
  int          loads_seen[2];
  int          cur_h, cur_m;

  always #5 clk = ~clk;

  rtc_set_ctrl dut0 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm), .cur_minl(cur_minl),
    .count_en(ce0), .load(ld0), .ld_hrm(hm0), .ld_hrl(hl0), .ld_minm(mm0),
    .ld_minl(ml0), .edit_field(ef0), .blink(bl0)
  );

  rtc_set_ctrl #(.AUTO_EXIT_S(3)) dut1 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm), .cur_minl(cur_minl),
    .count_en(ce1), .load(ld1), .ld_hrm(hm1), .ld_hrl(hl1), .ld_minm(mm1),
    .ld_minl(ml1), .edit_field(ef1), .blink(bl1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic set_cur(input int hh, input int mm);
    logic [7:0] hb, mb;
    cur_h = hh; cur_m = mm;
    hb = bcd(hh); mb = bcd(mm);
    cur_hrm = hb[7:4]; cur_hrl = hb[3:0]; cur_minm = mb[7:4]; cur_minl = mb[3:0];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k] = 0; h[k] = 0; mi[k] = 0; idle[k] = 0; bl[k] = 1'b0;
    end
  endtask

  // m: 0 running, 1 editing hours, 2 editing minutes, 3 loading
  task automatic model_step(input bit md, input bit in, input bit tk);
    for (int k = 0; k < 2; k++) begin
      case (m[k])
        0: if (md) begin
             m[k] = 1; h[k] = cur_h; mi[k] = cur_m; idle[k] = 0; bl[k] = 1'b0;
           end
        1, 2: begin
          if (md) begin
            m[k]++; idle[k] = 0;
            if (m[k] == 3) bl[k] = 1'b0; else if (tk) bl[k] = ~bl[k];
          end else if (in) begin
            if (m[k] == 1) h[k] = (h[k] + 1) % 24; else mi[k] = (mi[k] + 1) % 60;
            idle[k] = 0;
            if (tk) bl[k] = ~bl[k];
          end else if (tk) begin
            idle[k]++;
            if (lim[k] != 0 && idle[k] >= lim[k]) begin
              m[k] = 0; idle[k] = 0; bl[k] = 1'b0;
            end else bl[k] = ~bl[k];
          end
        end
        default: m[k] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic       o_ce, o_ld, o_bl;
      logic [1:0] o_ef;
      logic [15:0] o_val;
      o_ce  = k ? ce1 : ce0;
      o_ld  = k ? ld1 : ld0;
      o_bl  = k ? bl1 : bl0;
      o_ef  = k ? ef1 : ef0;
      o_val = k ? {hm1, hl1, mm1, ml1} : {hm0, hl0, mm0, ml0};
      if (o_ld === 1'b1) loads_seen[k]++;
      check($sformatf("count_en[%0d]", k), 32'(o_ce), 32'(m[k] == 0));
      check($sformatf("load[%0d]", k), 32'(o_ld), 32'(m[k] == 3));
      check($sformatf("edit_field[%0d]", k), 32'(o_ef), (m[k] == 1) ? 1 : (m[k] == 2) ? 2 : 0);
      check($sformatf("blink[%0d]", k), 32'(o_bl), 32'(bl[k]));
      check($sformatf("ld_time[%0d]", k), 32'(o_val), 32'({bcd(h[k]), bcd(mi[k])}));
    end
  endtask

  task automatic cyc(input bit md, input bit in, input bit tk);
    @(negedge clk);
    mode_btn = md; inc_btn = in; tick_1hz = tk;
    @(posedge clk);
    model_step(md, in, tk);
    #1;
    check_all();
    mode_btn = 1'b0; inc_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  // Reset asserted between edges; async outputs must already be at reset values.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    lim[0] = 30; lim[1] = 3;
    rst = 1'b0; tick_1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    loads_seen[0] = 0; loads_seen[1] = 0;
    set_cur(12, 34);
    model_reset();
    do_reset();

    // Idle after reset with free-running ticks: never a load.
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b0, (i % 10) == 0);
    check("no_load_1000", 32'(loads_seen[0] + loads_seen[1]), 0);

    // 12:34 -> three hour increments, thirty minute increments -> 15:04.
    set_cur(12, 34);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0);
    loads_seen[0] = 0;
    cyc(1'b1, 1'b0, 1'b0);
    check("commit_load", 32'(ld0), 1);
    check("commit_ce", 32'(ce0), 0);
    check("commit_val", 32'({hm0, hl0, mm0, ml0}), 32'h1504);
    cyc(1'b0, 1'b0, 1'b0);
    check("post_commit_ce", 32'(ce0), 1);
    check("single_load", 32'(loads_seen[0]), 1);

    // Hour wrap 22 -> 00, then minute wrap 58 -> 01 with hours untouched.
    do_reset();
    set_cur(22, 58);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("hour_wrap", 32'({hm0, hl0}), 32'h00);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    check("min_wrap", 32'({hm0, hl0, mm0, ml0}), 32'h0001);

    // Simultaneous mode+inc in hours: advance only.
    do_reset();
    set_cur(7, 15);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("mode_wins_ef", 32'(ef0), 2);
    check("mode_wins_hr", 32'({hm0, hl0}), 32'h07);

    // Timeout on the 3 s instance, then a press on the expiring tick.
    do_reset();
    loads_seen[1] = 0;
    set_cur(10, 20);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("timeout_pending", 32'(ef1), 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("timeout_ce", 32'(ce1), 1);
    check("timeout_ef", 32'(ef1), 0);
    check("timeout_noload", 32'(loads_seen[1]), 0);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("press_beats_timeout", 32'(ef1), 1);

    // Reset in the middle of minute edit: no load ever follows.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    do_reset();
    loads_seen[0] = 0; loads_seen[1] = 0;
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, (i % 4) == 0);
    check("rst_abort_noload", 32'(loads_seen[0] + loads_seen[1]), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
